// File: rtl/alu_bist.sv
// alu_bist: BIST sequencer that sweeps every ALU opcode with LFSR operands and folds the results into a MISR.
// Optional macro ALU_BIST_ZERO_CHECK_EN adds a sticky zero_err output that cross-checks the ALU zero flag.
//
// state  | meaning
// IDLE   | after reset; operands and signature hold
// RUN    | one vector per cycle, result folded into the MISR
// DONE   | sweep finished; signature and pass held until start or rst
module alu_bist #(
    parameter logic [31:0] SEED           = 32'h1,
    parameter int unsigned VECTORS_PER_OP = 64,
    parameter logic [3:0]  LAST_OP        = 4'd9,
    parameter logic [31:0] GOLDEN_SIG     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] result,
    input  logic        zero_flag,
    output logic [31:0] srcA,
    output logic [31:0] srcB,
    output logic [3:0]  ALU_sel,
    output logic        busy,
    output logic        done,
    output logic        pass,
`ifdef ALU_BIST_ZERO_CHECK_EN
    output logic        zero_err,
`endif
    output logic [31:0] signature
);

    localparam int CNT_W = (VECTORS_PER_OP > 1) ? $clog2(VECTORS_PER_OP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VECTORS_PER_OP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] vec_cnt;
    logic             run_entry;
    logic             last_vec;
    logic             sig_ok;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    assign run_entry = (state != S_RUN) && start;
    assign last_vec  = (state == S_RUN) && (vec_cnt == CNT_LAST) && (ALU_sel == LAST_OP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_vec) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef ALU_BIST_ZERO_CHECK_EN
    assign sig_ok = (signature == GOLDEN_SIG) && !zero_err;
`else
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag;
    assign sig_ok = (signature == GOLDEN_SIG);
`endif

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (state)
            S_RUN:  busy = 1'b1;
            S_DONE: begin
                done = 1'b1;
                pass = sig_ok;
            end
            default: ;
        endcase
    end

    // The final vector is captured without advancing operands or opcode, so DONE shows the last pattern applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            srcA      <= '0;
            srcB      <= '0;
            ALU_sel   <= '0;
            vec_cnt   <= '0;
            signature <= '0;
        end else if (run_entry) begin
            srcA      <= SEED;
            srcB      <= {SEED[15:0], SEED[31:16]};
            ALU_sel   <= '0;
            vec_cnt   <= '0;
            signature <= '0;
        end else if (state == S_RUN) begin
            signature <= lfsr_next(signature) ^ result;
            if (!last_vec) begin
                srcA <= lfsr_next(srcA);
                srcB <= lfsr_next(srcB);
                if (vec_cnt == CNT_LAST) begin
                    vec_cnt <= '0;
                    ALU_sel <= ALU_sel + 4'd1;
                end else begin
                    vec_cnt <= vec_cnt + 1'b1;
                end
            end
        end
    end

`ifdef ALU_BIST_ZERO_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_err <= 1'b0;
        end else if (run_entry) begin
            zero_err <= 1'b0;
        end else if ((state == S_RUN) && (zero_flag != (result == 32'h0))) begin
            zero_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: self-checking bench for alu_bist using a reference model of the sweep, LFSRs, ALU and MISR.
// Four instances cover the single-vector, two-vector, default and an odd-sized configuration.
module tb_alu_bist;

    localparam logic [31:0] R_SEED = 32'hACE12345;
    localparam int          N_DEF  = 640;
    localparam int          N_R    = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] step(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return {31'b0, $signed(a) < $signed(b)};
            4'd6: return {31'b0, a < b};
            4'd7: return a << b[4:0];
            4'd8: return a >> b[4:0];
            4'd9: return 32'($signed(a) >>> b[4:0]);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_sig(input logic [31:0] seed, input int vpo, input int last_op);
        logic [31:0] a, b, sig;
        a   = seed;
        b   = {seed[15:0], seed[31:16]};
        sig = 32'h0;
        for (int i = 0; i < (last_op + 1) * vpo; i++) begin
            sig = step(sig) ^ alu_ref(a, b, 4'(i / vpo));
            a   = step(a);
            b   = step(b);
        end
        return sig;
    endfunction

    // s: 1 vector, add stub (mode 1 corrupts bit 0)
    logic s_rst = 1'b1, s_start = 1'b0; int s_mode = 0;
    logic [31:0] s_srcA, s_srcB, s_sig, s_result; logic [3:0] s_op;
    logic s_busy, s_done, s_pass, s_zf;
    assign s_result = (s_srcA + s_srcB) ^ {31'b0, s_mode == 1};
    assign s_zf     = (s_result == 32'h0);
    // t: 2 vectors, add stub (mode 1 forces result=0, zero_flag=0)
    logic t_rst = 1'b1, t_start = 1'b0; int t_mode = 0;
    logic [31:0] t_srcA, t_srcB, t_sig, t_result; logic [3:0] t_op;
    logic t_busy, t_done, t_pass, t_zf;
    assign t_result = (t_mode == 1) ? 32'h0 : t_srcA + t_srcB;
    assign t_zf     = (t_mode == 1) ? 1'b0 : (t_result == 32'h0);
    // d: defaults, full ALU
    logic d_rst = 1'b1, d_start = 1'b0;
    logic [31:0] d_srcA, d_srcB, d_sig, d_result; logic [3:0] d_op;
    logic d_busy, d_done, d_pass, d_zf;
    assign d_result = alu_ref(d_srcA, d_srcB, d_op);
    assign d_zf     = (d_result == 32'h0);
    // r: odd configuration, full ALU
    logic r_rst = 1'b1, r_start = 1'b0;
    logic [31:0] r_srcA, r_srcB, r_sig, r_result; logic [3:0] r_op;
    logic r_busy, r_done, r_pass, r_zf;
    assign r_result = alu_ref(r_srcA, r_srcB, r_op);
    assign r_zf     = (r_result == 32'h0);

`ifdef ALU_BIST_ZERO_CHECK_EN
    logic s_zerr, t_zerr, d_zerr, r_zerr;
`endif

    alu_bist #(.SEED(32'h1), .VECTORS_PER_OP(1), .LAST_OP(4'd0), .GOLDEN_SIG(32'h00010001)) u_s (
        .clk(clk), .rst(s_rst), .start(s_start), .result(s_result), .zero_flag(s_zf),
        .srcA(s_srcA), .srcB(s_srcB), .ALU_sel(s_op), .busy(s_busy), .done(s_done), .pass(s_pass),
`ifdef ALU_BIST_ZERO_CHECK_EN
        .zero_err(s_zerr),
`endif
        .signature(s_sig));

    alu_bist #(.SEED(32'h1), .VECTORS_PER_OP(2), .LAST_OP(4'd0), .GOLDEN_SIG(32'h0)) u_t (
        .clk(clk), .rst(t_rst), .start(t_start), .result(t_result), .zero_flag(t_zf),
        .srcA(t_srcA), .srcB(t_srcB), .ALU_sel(t_op), .busy(t_busy), .done(t_done), .pass(t_pass),
`ifdef ALU_BIST_ZERO_CHECK_EN
        .zero_err(t_zerr),
`endif
        .signature(t_sig));

    alu_bist u_d (
        .clk(clk), .rst(d_rst), .start(d_start), .result(d_result), .zero_flag(d_zf),
        .srcA(d_srcA), .srcB(d_srcB), .ALU_sel(d_op), .busy(d_busy), .done(d_done), .pass(d_pass),
`ifdef ALU_BIST_ZERO_CHECK_EN
        .zero_err(d_zerr),
`endif
        .signature(d_sig));

    alu_bist #(.SEED(R_SEED), .VECTORS_PER_OP(5), .LAST_OP(4'd3), .GOLDEN_SIG(32'h0)) u_r (
        .clk(clk), .rst(r_rst), .start(r_start), .result(r_result), .zero_flag(r_zf),
        .srcA(r_srcA), .srcB(r_srcB), .ALU_sel(r_op), .busy(r_busy), .done(r_done), .pass(r_pass),
`ifdef ALU_BIST_ZERO_CHECK_EN
        .zero_err(r_zerr),
`endif
        .signature(r_sig));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick();
        tick();
        s_rst = 1'b0; t_rst = 1'b0; d_rst = 1'b0; r_rst = 1'b0;
        tick();
        n_tests++;
        if ({s_srcA, s_srcB, s_op, s_busy, s_done, s_pass, s_sig} !== 103'h0) begin
            n_fail++; $display("FAIL reset_s: got %h required 0", {s_srcA, s_srcB, s_op, s_busy, s_done, s_pass, s_sig});
        end
        n_tests++;
        if ({t_srcA, t_srcB, t_op, t_busy, t_done, t_pass, t_sig} !== 103'h0) begin
            n_fail++; $display("FAIL reset_t: got %h required 0", {t_srcA, t_srcB, t_op, t_busy, t_done, t_pass, t_sig});
        end
        n_tests++;
        if ({d_srcA, d_srcB, d_op, d_busy, d_done, d_pass, d_sig} !== 103'h0) begin
            n_fail++; $display("FAIL reset_d: got %h required 0", {d_srcA, d_srcB, d_op, d_busy, d_done, d_pass, d_sig});
        end
        n_tests++;
        if ({r_srcA, r_srcB, r_op, r_busy, r_done, r_pass, r_sig} !== 103'h0) begin
            n_fail++; $display("FAIL reset_r: got %h required 0", {r_srcA, r_srcB, r_op, r_busy, r_done, r_pass, r_sig});
        end
`ifdef ALU_BIST_ZERO_CHECK_EN
        n_tests++;
        if ({s_zerr, t_zerr, d_zerr, r_zerr} !== 4'h0) begin
            n_fail++; $display("FAIL reset_zero_err: got %b required 0000", {s_zerr, t_zerr, d_zerr, r_zerr});
        end
`endif
    endtask

    task automatic test_single_vector();
        s_mode = 0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        n_tests++;
        if ({s_srcA, s_srcB, s_op, s_busy, s_done} !== {32'h1, 32'h00010000, 4'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL single_edge0: srcA=%h srcB=%h sel=%0d busy=%b done=%b required 1/00010000/0/1/0",
                               s_srcA, s_srcB, s_op, s_busy, s_done);
        end
        tick();
        n_tests++;
        if ({s_sig, s_done, s_pass, s_busy} !== {32'h00010001, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL single_done: sig=%h done=%b pass=%b busy=%b required 00010001/1/1/0",
                               s_sig, s_done, s_pass, s_busy);
        end
        tick();
        n_tests++;
        if ({s_done, s_sig} !== {1'b1, 32'h00010001}) begin
            n_fail++; $display("FAIL single_hold: done=%b sig=%h required 1/00010001", s_done, s_sig);
        end
    endtask

    task automatic test_corrupt_result();
        s_mode = 1;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        n_tests++;
        if ({s_done, s_busy, s_pass, s_sig} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL restart_edge0: done=%b busy=%b pass=%b sig=%h required 0/1/0/0",
                               s_done, s_busy, s_pass, s_sig);
        end
        tick();
        n_tests++;
        if ({s_sig, s_done, s_pass} !== {32'h00010000, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL corrupt_done: sig=%h done=%b pass=%b required 00010000/1/0", s_sig, s_done, s_pass);
        end
        s_mode = 0;
    endtask

    task automatic test_two_vectors();
        logic [31:0] exp_sig;
        exp_sig = ref_sig(32'h1, 2, 0);
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        n_tests++;
        if ({t_srcA, t_srcB} !== {32'h1, 32'h00010000}) begin
            n_fail++; $display("FAIL two_vec0: srcA=%h srcB=%h required 1/00010000", t_srcA, t_srcB);
        end
        tick();
        n_tests++;
        if ({t_srcA, t_srcB, t_op, t_busy, t_done} !== {32'h3, 32'h00020000, 4'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL two_vec1: srcA=%h srcB=%h sel=%0d busy=%b done=%b required 3/00020000/0/1/0",
                               t_srcA, t_srcB, t_op, t_busy, t_done);
        end
        tick();
        n_tests++;
        if ({t_done, t_busy, t_sig, t_pass} !== {1'b1, 1'b0, exp_sig, exp_sig == 32'h0}) begin
            n_fail++; $display("FAIL two_done: done=%b busy=%b sig=%h pass=%b required 1/0/%h/%b",
                               t_done, t_busy, t_sig, t_pass, exp_sig, exp_sig == 32'h0);
        end
`ifdef ALU_BIST_ZERO_CHECK_EN
        n_tests++;
        if (t_zerr !== 1'b0) begin
            n_fail++; $display("FAIL two_zero_err: got %b required 0", t_zerr);
        end
`endif
    endtask

    // Full default sweep, checking every presented vector; start is pulsed once mid-run.
    task automatic run_default(input int pulse_at, input string tag);
        logic [31:0] ea, eb, exp_sig;
        int bad;
        ea = 32'h1;
        eb = 32'h00010000;
        exp_sig = ref_sig(32'h1, 64, 9);
        bad = 0;
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        for (int k = 0; k < N_DEF; k++) begin
            n_tests++;
            if ({d_srcA, d_srcB, d_op, d_busy, d_done} !== {ea, eb, 4'(k / 64), 1'b1, 1'b0}) begin
                n_fail++;
                if (bad < 5) $display("FAIL %s_vec%0d: srcA=%h srcB=%h sel=%0d busy=%b done=%b required %h/%h/%0d/1/0",
                                      tag, k, d_srcA, d_srcB, d_op, d_busy, d_done, ea, eb, k / 64);
                bad++;
            end
            ea = step(ea);
            eb = step(eb);
            d_start = (k + 1 == pulse_at);
            tick();
        end
        d_start = 1'b0;
        n_tests++;
        if ({d_done, d_busy, d_sig, d_pass} !== {1'b1, 1'b0, exp_sig, exp_sig == 32'h0}) begin
            n_fail++; $display("FAIL %s_done: done=%b busy=%b sig=%h pass=%b required 1/0/%h/%b",
                               tag, d_done, d_busy, d_sig, d_pass, exp_sig, exp_sig == 32'h0);
        end
    endtask

    task automatic test_full_run();
        run_default(int'($urandom_range(1, N_DEF - 1)), "full");
    endtask

    task automatic test_reset_mid_run();
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        for (int k = 1; k < 100; k++) tick();
        d_rst = 1'b1;
        tick();
        n_tests++;
        if ({d_srcA, d_srcB, d_op, d_busy, d_done, d_pass, d_sig} !== 103'h0) begin
            n_fail++; $display("FAIL midrun_reset: got %h required 0", {d_srcA, d_srcB, d_op, d_busy, d_done, d_pass, d_sig});
        end
        d_rst = 1'b0;
        tick();
        n_tests++;
        if ({d_busy, d_done} !== 2'b00) begin
            n_fail++; $display("FAIL midrun_idle: busy=%b done=%b required 0/0", d_busy, d_done);
        end
        run_default(int'($urandom_range(1, N_DEF - 1)), "rerun");
    endtask

    task automatic test_random_runs();
        logic [31:0] exp_sig;
        int gap, pulse_at;
        exp_sig = ref_sig(R_SEED, 5, 3);
        for (int it = 0; it < 4; it++) begin
            gap = int'($urandom_range(0, 5));
            pulse_at = int'($urandom_range(1, N_R - 1));
            for (int g = 0; g < gap; g++) tick();
            r_start = 1'b1;
            tick();
            r_start = 1'b0;
            for (int k = 1; k <= N_R; k++) begin
                r_start = (k == pulse_at);
                tick();
                if (k < N_R) begin
                    n_tests++;
                    if ({r_busy, r_done} !== 2'b10) begin
                        n_fail++; $display("FAIL rand%0d_edge%0d: busy=%b done=%b required 1/0", it, k, r_busy, r_done);
                    end
                end
            end
            r_start = 1'b0;
            n_tests++;
            if ({r_done, r_busy, r_sig, r_pass} !== {1'b1, 1'b0, exp_sig, exp_sig == 32'h0}) begin
                n_fail++; $display("FAIL rand%0d_done: done=%b busy=%b sig=%h pass=%b required 1/0/%h/%b",
                                   it, r_done, r_busy, r_sig, r_pass, exp_sig, exp_sig == 32'h0);
            end
        end
    endtask

`ifdef ALU_BIST_ZERO_CHECK_EN
    task automatic test_zero_check();
        t_mode = 1;
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        n_tests++;
        if (t_zerr !== 1'b0) begin
            n_fail++; $display("FAIL zero_entry: zero_err=%b required 0", t_zerr);
        end
        tick();
        n_tests++;
        if (t_zerr !== 1'b1) begin
            n_fail++; $display("FAIL zero_set: zero_err=%b required 1", t_zerr);
        end
        tick();
        n_tests++;
        if ({t_done, t_sig, t_pass, t_zerr} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL zero_done: done=%b sig=%h pass=%b zero_err=%b required 1/0/0/1",
                               t_done, t_sig, t_pass, t_zerr);
        end
        t_mode = 0;
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_single_vector();
        test_corrupt_result();
        test_two_vectors();
        test_full_run();
        test_reset_mid_run();
        test_random_runs();
`ifdef ALU_BIST_ZERO_CHECK_EN
        test_zero_check();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
